// File: rtl/alu_arbiter_if.sv
// Handshake and operand bundle between the two ALU requesters, the shared ALU
// and the response consumer. The arbiter takes the slave view; the
// surrounding environment (requesters, ALU, consumer) takes the master view.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CTRLW = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [CTRLW-1:0] req0_ctrl;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [CTRLW-1:0] req1_ctrl;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [CTRLW-1:0] alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    output req1_ready,
    output alu_a, alu_b, alu_control,
    input  alu_result, alu_zero,
    output rsp_valid, rsp_id, rsp_result, rsp_zero,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    input  req1_ready,
    input  alu_a, alu_b, alu_control,
    output alu_result, alu_zero,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant, one issue register feeding the ALU operands and one
// response register returning the result tagged with the requester id.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: req0 always wins a tie
// (req1 may starve; intended for bring-up only).
//
// state | meaning ({iss_valid, rsp_valid})
// EMPTY | 00 nothing in flight
// RESP  | 01 only the response register holds a result
// ISSUE | 10 only the issue register holds an operation
// FULL  | 11 both registers occupied
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CTRLW = 4
) (
  input logic         clk,
  input logic         reset,
  alu_arbiter_if.slave bus
);
  localparam logic [CTRLW-1:0] CTRL_IDLE = CTRLW'(4'b1010);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    RESP  = 2'b01,
    ISSUE = 2'b10,
    FULL  = 2'b11
  } occ_t;

  occ_t             state;
  logic             iss_id;
  logic [WIDTH-1:0] iss_a;
  logic [WIDTH-1:0] iss_b;
  logic [CTRLW-1:0] iss_ctrl;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q;

  logic iss_valid;
  logic rsp_valid;
  logic adv;
  logic free;
  logic any_valid;
  logic grant;
  logic accept;

  assign iss_valid = state[1];
  assign rsp_valid = state[0];
  assign adv       = iss_valid & (~rsp_valid | bus.rsp_ready);
  assign free      = ~iss_valid | adv;
  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign accept    = free & any_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority: req1 is granted only when req0 is idle
  always_comb begin
    grant = ~bus.req0_valid;
  end
`else
  logic last_grant;

  // Round-robin: a tie goes to the requester not served last
  always_comb begin
    grant = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant;
    end
  end

  // History moves only on an accepted handshake; reset to 1 so req0 wins the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant;
    end
  end
`endif

  assign bus.req0_ready = accept & ~grant;
  assign bus.req1_ready = accept & grant;

  // Occupancy FSM plus issue and response registers; an accept overrides the issue-reg clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= EMPTY;
      iss_id       <= 1'b0;
      iss_a        <= '0;
      iss_b        <= '0;
      iss_ctrl     <= CTRL_IDLE;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state <= occ_t'({accept | (iss_valid & ~adv), adv | (rsp_valid & ~bus.rsp_ready)});
      if (accept) begin
        iss_id   <= grant;
        iss_a    <= grant ? bus.req1_a    : bus.req0_a;
        iss_b    <= grant ? bus.req1_b    : bus.req0_b;
        iss_ctrl <= grant ? bus.req1_ctrl : bus.req0_ctrl;
      end else if (adv) begin
        // Park the ALU on add 0+0 so its inputs stop toggling while idle
        iss_id   <= 1'b0;
        iss_a    <= '0;
        iss_b    <= '0;
        iss_ctrl <= CTRL_IDLE;
      end
      if (adv) begin
        rsp_id_q     <= iss_id;
        rsp_result_q <= bus.alu_result;
        rsp_zero_q   <= bus.alu_zero;
      end
    end
  end

  assign bus.alu_a       = iss_a;
  assign bus.alu_b       = iss_b;
  assign bus.alu_control = iss_ctrl;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_zero    = rsp_zero_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a reference ALU and a response scoreboard.
module tb_alu_arbiter;
  localparam int W  = 32;
  localparam int CW = 4;
  localparam logic [CW-1:0] ADD = 4'b1010;
  localparam logic [CW-1:0] SUB = 4'b1110;
  localparam logic [CW-1:0] AND = 4'b0000;
  localparam logic [CW-1:0] OR  = 4'b0001;
  localparam logic [CW-1:0] NOR = 4'b0011;
  localparam logic [CW-1:0] SLT = 4'b0101;

  typedef struct {
    logic         id;
    logic [W-1:0] res;
    logic         zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   compared = 0;
  int   mismatched = 0;
  exp_t sb[$];
  logic exp_g;

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W), .CTRLW(CW)) bus ();

  alu_arbiter #(.WIDTH(W), .CTRLW(CW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [CW-1:0] c);
    case (c)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      NOR:     return ~(a | b);
      SLT:     return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_control);
  assign bus.alu_zero   = (bus.alu_result == '0);

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: record accepted requests, compare delivered responses
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", W'(1), W'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id", W'(bus.rsp_id), W'(e.id));
          chk("rsp_result", bus.rsp_result, e.res);
          chk("rsp_zero", W'(bus.rsp_zero), W'(e.zero));
        end
      end
      if (bus.req0_valid && bus.req0_ready) begin
        exp_t e;
        e.id   = 1'b0;
        e.res  = alu_f(bus.req0_a, bus.req0_b, bus.req0_ctrl);
        e.zero = (e.res == '0);
        sb.push_back(e);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        exp_t e;
        e.id   = 1'b1;
        e.res  = alu_f(bus.req1_a, bus.req1_b, bus.req1_ctrl);
        e.zero = (e.res == '0);
        sb.push_back(e);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctrl = ADD;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctrl = ADD;
    bus.rsp_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", W'(bus.rsp_valid), W'(0));
    chk("rst_rsp_id", W'(bus.rsp_id), W'(0));
    chk("rst_rsp_result", bus.rsp_result, W'(0));
    chk("rst_rsp_zero", W'(bus.rsp_zero), W'(0));
    chk("rst_alu_a", bus.alu_a, W'(0));
    chk("rst_alu_b", bus.alu_b, W'(0));
    chk("rst_alu_ctrl", W'(bus.alu_control), W'(ADD));
    rst_n = 1'b1;
    tick();

    // Single op: req0 add 5+7
    bus.req0_valid = 1'b1; bus.req0_a = 5; bus.req0_b = 7; bus.req0_ctrl = ADD;
    @(negedge clk);
    chk("single_req0_ready", W'(bus.req0_ready), W'(1));
    chk("single_req1_ready", W'(bus.req1_ready), W'(0));
    tick();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("single_rsp_valid_E", W'(bus.rsp_valid), W'(0));
    chk("single_alu_a", bus.alu_a, W'(5));
    chk("single_alu_b", bus.alu_b, W'(7));
    tick();
    @(negedge clk);
    chk("single_rsp_valid_E1", W'(bus.rsp_valid), W'(1));
    chk("single_rsp_result", bus.rsp_result, W'(12));
    chk("single_alu_idle", bus.alu_a, W'(0));
    tick();
    tick();

    // Fairness: req1 alone for three cycles, then a tie
    for (int i = 0; i < 3; i++) begin
      bus.req1_valid = 1'b1; bus.req1_a = W'(i + 1); bus.req1_b = 3; bus.req1_ctrl = OR;
      @(negedge clk);
      chk("solo_req1_ready", W'(bus.req1_ready), W'(1));
      chk("solo_req0_ready", W'(bus.req0_ready), W'(0));
      tick();
    end
    bus.req0_valid = 1'b1; bus.req0_a = 100; bus.req0_b = 1; bus.req0_ctrl = SUB;
    bus.req1_a = 9; bus.req1_b = 9; bus.req1_ctrl = SUB;

    // Tie stream: grants alternate starting with req0
    exp_g = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("tie_req0_ready", W'(bus.req0_ready), W'(exp_g == 1'b0));
      chk("tie_req1_ready", W'(bus.req1_ready), W'(exp_g == 1'b1));
      tick();
      if (exp_g == 1'b0) begin
        bus.req0_a = W'(i * 7 + 3); bus.req0_b = W'(i); bus.req0_ctrl = ADD;
      end else begin
        bus.req1_a = W'(i + 10); bus.req1_b = 5; bus.req1_ctrl = (i % 4 == 1) ? NOR : SLT;
      end
`ifndef ALU_ARB_FIXED_PRIO_EN
      exp_g = ~exp_g;
`endif
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (3) tick();
    chk("tie_sb_drained", W'(sb.size()), W'(0));

    // Backpressure: two accepts with the consumer stalled
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 20; bus.req0_b = 22; bus.req0_ctrl = ADD;
    @(negedge clk);
    chk("bp_accept1", W'(bus.req0_ready), W'(1));
    tick();
    bus.req0_a = 32'hFFFF_FFFF; bus.req0_b = 1; bus.req0_ctrl = ADD;
    @(negedge clk);
    chk("bp_accept2", W'(bus.req0_ready), W'(1));
    tick();
    bus.req0_a = 1; bus.req0_b = 1;
    bus.req1_valid = 1'b1; bus.req1_a = 2; bus.req1_b = 2; bus.req1_ctrl = ADD;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_req0_ready", W'(bus.req0_ready), W'(0));
      chk("bp_req1_ready", W'(bus.req1_ready), W'(0));
      chk("bp_rsp_valid", W'(bus.rsp_valid), W'(1));
      chk("bp_rsp_hold", bus.rsp_result, W'(42));
      chk("bp_iss_hold", bus.alu_a, 32'hFFFF_FFFF);
      tick();
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_result", bus.rsp_result, W'(42));
    tick();
    @(negedge clk);
    chk("bp_drain_adv_valid", W'(bus.rsp_valid), W'(1));
    chk("bp_second_result", bus.rsp_result, W'(0));
    chk("bp_second_zero", W'(bus.rsp_zero), W'(1));
    tick();
    @(negedge clk);
    chk("bp_empty", W'(bus.rsp_valid), W'(0));
    chk("bp_sb_drained", W'(sb.size()), W'(0));

    // Reset with both registers full
    tick();
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 3; bus.req0_b = 4; bus.req0_ctrl = ADD;
    tick();
    bus.req0_a = 6; bus.req0_b = 6; bus.req0_ctrl = SUB;
    tick();
    bus.req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", W'(bus.rsp_valid), W'(0));
    chk("midrst_alu_a", bus.alu_a, W'(0));
    chk("midrst_alu_ctrl", W'(bus.alu_control), W'(ADD));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", W'(bus.rsp_valid), W'(0));
    end
    tick();
    bus.req0_valid = 1'b1; bus.req0_a = 11; bus.req0_b = 4; bus.req0_ctrl = SUB;
    bus.req1_valid = 1'b1; bus.req1_a = 1; bus.req1_b = 2; bus.req1_ctrl = AND;
    @(negedge clk);
    chk("midrst_tie_req0", W'(bus.req0_ready), W'(1));
    chk("midrst_tie_req1", W'(bus.req1_ready), W'(0));
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (3) tick();
    chk("final_sb_drained", W'(sb.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
